// File: rtl/run_ctrl.sv
// Run controller for the single-cycle RV core: holds core reset, lets the core run, stops on ECALL/EBREAK, PC self-loop or cycle budget.
// Optional PC path signature enabled by defining RUN_CTRL_SIG_EN.
module run_ctrl #(
   parameter int RST_CYCLES  = 2,
   parameter int MAX_CYCLES  = 38,
   parameter int STALL_LIMIT = 4,
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32,
   localparam int CNT_WIDTH  = $clog2(MAX_CYCLES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic                   core_reset,
   output logic                   running,
   output logic                   done,
   output logic                   halted,
   output logic                   timeout,
   output logic [CNT_WIDTH-1:0]   cycle_count,
   output logic [PC_WIDTH-1:0]    pc_sig
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

   typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

   state_t                state;
   logic [RW-1:0]         rst_cnt;
   logic [SW-1:0]         stall_cnt;
   logic [SW-1:0]         stall_inc;
   logic [PC_WIDTH-1:0]   prev_pc;
   logic                  prev_valid;
   logic                  is_sys;
   logic                  pc_same;
   logic                  loop_hit;
   logic                  budget_hit;

   // Termination conditions for the current RUN cycle; halt outranks the budget.
   always_comb begin
      is_sys     = (instr == INSTR_WIDTH'(32'h00000073)) || (instr == INSTR_WIDTH'(32'h00100073));
      pc_same    = prev_valid && (pc == prev_pc);
      stall_inc  = stall_cnt + SW'(1);
      loop_hit   = (STALL_LIMIT > 0) && pc_same && (stall_inc == SW'(STALL_LIMIT));
      budget_hit = (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         core_reset  <= 1'b1;
         running     <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         rst_cnt     <= '0;
         stall_cnt   <= '0;
         prev_pc     <= '0;
         prev_valid  <= 1'b0;
`ifdef RUN_CTRL_SIG_EN
         pc_sig      <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= RST;
                  core_reset  <= 1'b1;
                  running     <= 1'b0;
                  done        <= 1'b0;
                  halted      <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
                  rst_cnt     <= '0;
                  stall_cnt   <= '0;
                  prev_valid  <= 1'b0;
`ifdef RUN_CTRL_SIG_EN
                  pc_sig      <= '0;
`endif
               end
            end
            RST: begin
               if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  running    <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + RW'(1);
               end
            end
            RUN: begin
               cycle_count <= cycle_count + CNT_WIDTH'(1);
               prev_pc     <= pc;
               prev_valid  <= 1'b1;
               stall_cnt   <= pc_same ? stall_inc : '0;
`ifdef RUN_CTRL_SIG_EN
               pc_sig      <= {pc_sig[PC_WIDTH-2:0], pc_sig[PC_WIDTH-1]} ^ pc;
`endif
               if (is_sys || loop_hit) begin
                  state      <= DONE;
                  halted     <= 1'b1;
                  done       <= 1'b1;
                  running    <= 1'b0;
                  core_reset <= 1'b1;
               end else if (budget_hit) begin
                  state      <= DONE;
                  timeout    <= 1'b1;
                  done       <= 1'b1;
                  running    <= 1'b0;
                  core_reset <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef RUN_CTRL_SIG_EN
   assign pc_sig = '0;
`endif

endmodule
